calc_driver: RTL and testbench
==============================

CALC_DRIVER -- requirements
Module: calc_driver

Interface
REQ-001 Parameter: LOAD_CYCLES, default 2, number of cycles calc_input_valid_o is held high per operation (legal range 1-15).
REQ-002 Parameter: CLEAR_CYCLES, default 2, number of cycles calc_clear_o is held high per operation (legal range 1-15).
REQ-003 Parameter: TIMEOUT, default 16, maximum number of CALC cycles spent waiting for calc_output_valid_i (legal range 1-255).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  operation request valid.
REQ-007 req_ready_o  output  1  driver can accept a request.
REQ-008 req_a_i / req_b_i  input  5 each  operands.
REQ-009 req_mode_i  input  1  calculator mode for this operation.
REQ-010 calc_a_o / calc_b_o  output  5 each  operands driven to calculator.
REQ-011 calc_mode_o  output  1  mode driven to calculator.
REQ-012 calc_input_valid_o, calc_calc_o, calc_clear_o  output  1 each  calculator control strobes.
REQ-013 calc_result_i  input  5  calculator result.
REQ-014 calc_output_valid_i  input  1  calculator result valid.
REQ-015 resp_valid_o  output  1  response valid.
REQ-016 resp_ready_i  input  1  consumer accepts response.
REQ-017 resp_result_o  output  5  captured result.
REQ-018 resp_timeout_o  output  1  response produced by timeout, not by calc_output_valid_i.
REQ-019 op_count_o  output  8  number of completed responses, modulo 256.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, CALC, CLEAR, RESP; all outputs are registered or decoded from registered state only.
REQ-021 req_ready_o SHALL be 1 exactly when state is IDLE and reset is low.
REQ-022 Handshake: request accepted on the rising edge with req_valid_i=1 and req_ready_o=1; a, b, mode are latched into internal registers; the state goes to LOAD.
REQ-023 calc_a_o, calc_b_o and calc_mode_o SHALL drive the latched values and stay stable from acceptance until the next acceptance; request inputs are ignored outside IDLE.
REQ-024 LOAD: calc_input_valid_o=1 for exactly LOAD_CYCLES cycles, then CALC.
REQ-025 CALC: calc_calc_o=1 in every CALC cycle; a per-operation wait counter starts at 0 on CALC entry.
REQ-026 CALC exit: on an edge with calc_output_valid_i=1, capture calc_result_i into resp_result_o, clear resp_timeout_o, and go to CLEAR.
REQ-027 CALC timeout: if calc_output_valid_i has not been sampled high by the TIMEOUT-th CALC cycle, set resp_result_o=0 and resp_timeout_o=1, then go to CLEAR.
REQ-028 calc_output_valid_i SHALL be ignored in all states other than CALC.
REQ-029 CLEAR: calc_clear_o=1 for exactly CLEAR_CYCLES cycles, with calc_calc_o=0 and calc_input_valid_o=0, then RESP.
REQ-030 RESP: resp_valid_o=1; resp_result_o and resp_timeout_o are held stable until the edge with resp_ready_i=1, which returns the state to IDLE and increments op_count_o (255 wraps to 0).
REQ-031 At most one of calc_input_valid_o, calc_calc_o, calc_clear_o SHALL be high in any cycle.
REQ-032 Latency with defaults and a result on the first CALC cycle: acceptance at edge 0; LOAD in cycles 1-2; CALC in cycle 3; CLEAR in cycles 4-5; resp_valid_o=1 from cycle 6.
REQ-033 resp_ready_i asserted outside RESP SHALL have no effect.

Reset
REQ-034 While reset is high (asynchronous):
- state = IDLE
- all calc_* outputs, resp_valid_o, resp_result_o, resp_timeout_o and op_count_o = 0
- internal counters = 0
- req_ready_o = 0
REQ-035 Reset asserted mid-operation (any state) SHALL abort the operation immediately with no response produced and op_count_o = 0.
REQ-036 In the first cycle after reset deassertion, req_ready_o SHALL be 1.

Verification
REQ-037 Basic op: a=3, b=4, mode=0 accepted; model returns 7 with output_valid on the first CALC cycle -> exact strobe timing per REQ-032; resp_result_o=7, resp_timeout_o=0, op_count_o=1.
REQ-038 Delayed result: model asserts output_valid on the 5th CALC cycle with result 21 -> calc_calc_o high for exactly 5 cycles; resp_result_o=21.
REQ-039 Timeout: model never asserts output_valid -> exactly 16 CALC cycles, then CLEAR for 2 cycles; resp_result_o=0, resp_timeout_o=1.
REQ-040 Backpressure: resp_ready_i held low for 10 cycles -> resp_valid_o and resp_result_o stable; req_ready_o=0 throughout; a req_valid_i pulse during this time is not accepted.
REQ-041 Reset in CALC: reset pulsed for 1 cycle -> all strobes drop within the same cycle; no response; req_ready_o=1 in the first cycle after reset.
REQ-042 Wrap: 256 back-to-back operations -> op_count_o reads 0 after the 256th response, with no idle gap beyond the single IDLE cycle per operation.

Source files
------------

// File: rtl/calc_driver.sv
// Sequences one operation at a time into a simple calculator: load strobe,
// calc strobe until a result or a timeout, clear strobe, then a held response.
module calc_driver #(
    parameter int LOAD_CYCLES  = 2,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [4:0] req_a_i,
    input  logic [4:0] req_b_i,
    input  logic       req_mode_i,

    output logic [4:0] calc_a_o,
    output logic [4:0] calc_b_o,
    output logic       calc_mode_o,
    output logic       calc_input_valid_o,
    output logic       calc_calc_o,
    output logic       calc_clear_o,
    input  logic [4:0] calc_result_i,
    input  logic       calc_output_valid_i,

    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic [4:0] resp_result_o,
    output logic       resp_timeout_o,
    output logic [7:0] op_count_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        CLEAR = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [7:0] LOAD_LAST  = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] CALC_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic [4:0] a_reg;
    logic [4:0] b_reg;
    logic       mode_reg;
    logic [4:0] result_reg;
    logic       timeout_reg;
    logic [7:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mode_reg    <= 1'b0;
            result_reg  <= '0;
            timeout_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        a_reg     <= req_a_i;
                        b_reg     <= req_b_i;
                        mode_reg  <= req_mode_i;
                        cnt_reg   <= '0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_reg == LOAD_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                CALC: begin
                    // A result on the last allowed cycle still wins over the timeout.
                    if (calc_output_valid_i) begin
                        result_reg  <= calc_result_i;
                        timeout_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= CLEAR;
                    end else if (cnt_reg == CALC_LAST) begin
                        result_reg  <= '0;
                        timeout_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= CLEAR;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                CLEAR: begin
                    if (cnt_reg == CLEAR_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        count_reg <= count_reg + 8'd1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes are pure state decodes so an asynchronous reset drops them at once.
    assign req_ready_o        = (state_reg == IDLE) && !reset;
    assign calc_input_valid_o = (state_reg == LOAD);
    assign calc_calc_o        = (state_reg == CALC);
    assign calc_clear_o       = (state_reg == CLEAR);
    assign resp_valid_o       = (state_reg == RESP);

    assign calc_a_o       = a_reg;
    assign calc_b_o       = b_reg;
    assign calc_mode_o    = mode_reg;
    assign resp_result_o  = result_reg;
    assign resp_timeout_o = timeout_reg;
    assign op_count_o     = count_reg;

endmodule

// File: tb/tb_calc_driver.sv
// Self-checking bench for calc_driver: timeline model compared every cycle,
// plus directed operations with hand-computed expectations.
module tb_calc_driver;

    localparam int L = 2;
    localparam int C = 2;
    localparam int T = 16;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_CALC  = 2;
    localparam int P_CLEAR = 3;
    localparam int P_RESP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [4:0] req_a_i = '0;
    logic [4:0] req_b_i = '0;
    logic       req_mode_i = 1'b0;
    logic [4:0] calc_a_o;
    logic [4:0] calc_b_o;
    logic       calc_mode_o;
    logic       calc_input_valid_o;
    logic       calc_calc_o;
    logic       calc_clear_o;
    logic [4:0] calc_result_i = '0;
    logic       calc_output_valid_i = 1'b0;
    logic       resp_valid_o;
    logic       resp_ready_i = 1'b0;
    logic [4:0] resp_result_o;
    logic       resp_timeout_o;
    logic [7:0] op_count_o;

    int checks = 0;
    int fails  = 0;

    calc_driver #(
        .LOAD_CYCLES (L),
        .CLEAR_CYCLES(C),
        .TIMEOUT     (T)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .req_mode_i         (req_mode_i),
        .calc_a_o           (calc_a_o),
        .calc_b_o           (calc_b_o),
        .calc_mode_o        (calc_mode_o),
        .calc_input_valid_o (calc_input_valid_o),
        .calc_calc_o        (calc_calc_o),
        .calc_clear_o       (calc_clear_o),
        .calc_result_i      (calc_result_i),
        .calc_output_valid_i(calc_output_valid_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_result_o      (resp_result_o),
        .resp_timeout_o     (resp_timeout_o),
        .op_count_o         (op_count_o)
    );

    always #5 clk = ~clk;

    // ---------------- timeline model ----------------
    int         cyc      = 0;
    bit         m_busy   = 0;
    int         m_accept = 0;
    int         m_calc_n = 0;   // 0 while the result is still outstanding
    logic [4:0] m_a = '0, m_b = '0, m_result = '0;
    logic       m_mode = 1'b0, m_timeout = 1'b0;
    int         m_count = 0;

    function automatic int phase_of(int c);
        int rel;
        if (!m_busy) return P_IDLE;
        rel = c - m_accept;
        if (rel <= L) return P_LOAD;
        if (m_calc_n == 0 || rel <= L + m_calc_n) return P_CALC;
        if (rel <= L + m_calc_n + C) return P_CLEAR;
        return P_RESP;
    endfunction

    int mph;
    int mk;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; m_busy = 0; m_accept = 0; m_calc_n = 0;
            m_a = '0; m_b = '0; m_mode = 1'b0;
            m_result = '0; m_timeout = 1'b0; m_count = 0;
        end else begin
            mph = phase_of(cyc);
            if (mph == P_IDLE && req_valid_i) begin
                m_busy = 1; m_accept = cyc; m_calc_n = 0;
                m_a = req_a_i; m_b = req_b_i; m_mode = req_mode_i;
            end else if (mph == P_CALC) begin
                mk = cyc - m_accept - L;
                if (calc_output_valid_i) begin
                    m_calc_n = mk; m_result = calc_result_i; m_timeout = 1'b0;
                end else if (mk == T) begin
                    m_calc_n = mk; m_result = '0; m_timeout = 1'b1;
                end
            end else if (mph == P_RESP && resp_ready_i) begin
                m_busy = 0;
                m_count = (m_count + 1) % 256;
            end
            cyc = cyc + 1;
        end
    end

    int          cph;
    logic [29:0] exp_v, act_v;
    always @(negedge clk) begin
        cph = phase_of(cyc);
        exp_v = {(!reset && cph == P_IDLE), cph == P_LOAD, cph == P_CALC, cph == P_CLEAR,
                 cph == P_RESP, m_result, m_timeout, 8'(m_count), m_a, m_b, m_mode};
        act_v = {req_ready_o, calc_input_valid_o, calc_calc_o, calc_clear_o, resp_valid_o,
                 resp_result_o, resp_timeout_o, op_count_o, calc_a_o, calc_b_o, calc_mode_o};
        checks++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL cycle_model cyc=%0d: got rdy/iv/calc/clr/rv=%b res=%0d to=%b cnt=%0d a=%0d b=%0d m=%b, expected %b res=%0d to=%b cnt=%0d a=%0d b=%0d m=%b",
                     cyc, act_v[29:25], act_v[24:20], act_v[19], act_v[18:11], act_v[10:6], act_v[5:1], act_v[0],
                     exp_v[29:25], exp_v[24:20], exp_v[19], exp_v[18:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // single IDLE cycle that follows the response handshake.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic mode,
                          input int k, input logic [4:0] res, input int hold, input bit noise,
                          output int n_load, output int n_calc, output int n_clear,
                          output int n_resp, output int first_resp,
                          output int r_res, output int r_to);
        int ncalc, total;
        ncalc = (k >= 1 && k <= T) ? k : T;
        total = L + ncalc + C;
        n_load = 0; n_calc = 0; n_clear = 0; n_resp = 0; first_resp = -1; r_res = -1; r_to = -1;
        req_valid_i = 1'b1; req_a_i = a; req_b_i = b; req_mode_i = mode;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; req_a_i = ~a; req_b_i = ~b; req_mode_i = ~mode;
        for (int j = 1; j <= total + hold + 1; j++) begin
            n_load  += int'(calc_input_valid_o);
            n_calc  += int'(calc_calc_o);
            n_clear += int'(calc_clear_o);
            n_resp  += int'(resp_valid_o);
            if (resp_valid_o && first_resp < 0) begin
                first_resp = j; r_res = int'(resp_result_o); r_to = int'(resp_timeout_o);
            end
            calc_output_valid_i = 1'b0;
            calc_result_i = 5'($urandom);
            if (k >= 1 && j == L + k) begin
                calc_output_valid_i = 1'b1; calc_result_i = res;
            end else if (noise && (j <= L || j > L + ncalc) && j <= total) begin
                calc_output_valid_i = 1'b1;
            end
            resp_ready_i = (j == total + hold + 1) || (noise && j == 1);
            req_valid_i  = noise && (j > total);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready_i = 1'b0; req_valid_i = 1'b0; calc_output_valid_i = 1'b0;
        $display("op a=%0d b=%0d mode=%0d: calc_cycles=%0d result=%0d timeout=%0d count=%0d",
                 a, b, mode, n_calc, r_res, r_to, op_count_o);
    endtask

    int nl, nc, ncl, nr, fr, rr, rt;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(req_ready_o), 0);
        chk("reset_count", int'(op_count_o), 0);
        chk("reset_strobes", int'({calc_input_valid_o, calc_calc_o, calc_clear_o, resp_valid_o}), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready_o), 1);

        // Basic op: result on the first CALC cycle
        run_op(5'd3, 5'd4, 1'b0, 1, 5'd7, 0, 1'b0, nl, nc, ncl, nr, fr, rr, rt);
        chk("basic_load_cycles", nl, 2);
        chk("basic_calc_cycles", nc, 1);
        chk("basic_clear_cycles", ncl, 2);
        chk("basic_first_resp", fr, 6);
        chk("basic_result", rr, 7);
        chk("basic_timeout", rt, 0);
        chk("basic_count", int'(op_count_o), 1);

        // Delayed result on the 5th CALC cycle, noise outside CALC
        run_op(5'd10, 5'd11, 1'b1, 5, 5'd21, 0, 1'b1, nl, nc, ncl, nr, fr, rr, rt);
        chk("delay_calc_cycles", nc, 5);
        chk("delay_result", rr, 21);
        chk("delay_timeout", rt, 0);

        // Timeout: result never arrives
        run_op(5'd1, 5'd2, 1'b0, 0, 5'd0, 0, 1'b1, nl, nc, ncl, nr, fr, rr, rt);
        chk("timeout_calc_cycles", nc, 16);
        chk("timeout_clear_cycles", ncl, 2);
        chk("timeout_first_resp", fr, 21);
        chk("timeout_result", rr, 0);
        chk("timeout_flag", rt, 1);

        // Backpressure: 10 cycles of resp_ready low
        run_op(5'd31, 5'd31, 1'b1, 2, 5'd30, 10, 1'b1, nl, nc, ncl, nr, fr, rr, rt);
        chk("bp_resp_cycles", nr, 11);
        chk("bp_first_resp", fr, 7);
        chk("bp_result", rr, 30);
        chk("bp_count", int'(op_count_o), 4);

        // Reset in the middle of CALC
        req_valid_i = 1'b1; req_a_i = 5'd9; req_b_i = 5'd6; req_mode_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (L + 2) @(negedge clk);
        chk("pre_reset_calc", int'(calc_calc_o), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_strobes", int'({calc_input_valid_o, calc_calc_o, calc_clear_o, resp_valid_o}), 0);
        chk("async_count", int'(op_count_o), 0);
        chk("async_ready", int'(req_ready_o), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", int'(req_ready_o), 1);
        chk("no_resp_after_reset", int'(resp_valid_o), 0);

        // Wrap: 256 back-to-back operations
        for (int i = 0; i < 256; i++) begin
            run_op(5'(i), 5'(i + 1), 1'(i), 1 + (i % 3), 5'(i * 7), 0, 1'b0,
                   nl, nc, ncl, nr, fr, rr, rt);
            if (i == 254) chk("count_255", int'(op_count_o), 255);
        end
        chk("count_wrap", int'(op_count_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
